openfire_mem_arbiter: RTL and testbench
=======================================

Name: openfire_mem_arbiter

Overview:
- Shares one external single-port memory between the CPU instruction-fetch port and data port.
- Sits between the CPU top level and the memory bus.
- Serialises each CPU cycle's data access and instruction fetch over a req/ack bus. Data goes first because it belongs to the older instruction.
- Holds the CPU `stall` input high until both accesses complete. Keeps a one-entry fetch buffer so repeated fetches of the same address skip the bus.

Parameters:
- TIMEOUT, 255: cycles `mem_req` may stay high without `mem_ack` before the access is aborted.
- TIMEOUT_W, 8: width of the watchdog counter. Must satisfy 2^TIMEOUT_W > TIMEOUT.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_addr  in  32  CPU fetch address, word address.
- dmem_addr  in  32  CPU data address, word address.
- dmem_data_out  in  32  CPU store data.
- dmem_we  in  1  CPU store request for this cycle.
- dmem_re  in  1  CPU load request for this cycle.
- imem_data_in  out  32  instruction to CPU.
- dmem_data_in  out  32  load data to CPU.
- stall  out  1  CPU stall.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  bus address.
- mem_wdata  out  32  bus write data.
- mem_rdata  in  32  bus read data, valid when `mem_ack` is high.
- mem_ack  in  1  bus acknowledge.
- bus_error  out  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0 except `stall`=1. State IDLE, buffer invalid, watchdog 0.
- Reset asserted mid-transfer drops `mem_req` immediately (asynchronous). No partial data is latched.

FSM states: IDLE, DACC, IFETCH, DONE.
- IDLE (stall=1): sample the CPU inputs into internal registers.
  - If `dmem_we` or `dmem_re` is high, go to DACC.
  - Else, if the fetch buffer misses, go to IFETCH.
  - Else go to DONE.
  - `dmem_we` and `dmem_re` both high: treated as a store, `dmem_re` ignored.
- DACC (stall=1):
  - `mem_req`=1, `mem_addr`=latched `dmem_addr`, `mem_we`=latched `dmem_we`, `mem_wdata`=latched store data.
  - On the edge where `mem_ack`=1 for a load: capture `mem_rdata` into `dmem_data_in`.
  - For a store whose address equals the buffered fetch address: invalidate the buffer.
  - Next state is IFETCH on buffer miss, else DONE.
  - On a DACC→IFETCH transition `mem_req` stays high and only address and `we` change (back-to-back, no idle cycle).
- IFETCH (stall=1):
  - `mem_req`=1, `mem_we`=0, `mem_addr`=latched `imem_addr`.
  - On ack: capture `mem_rdata` into `imem_data_in` and into the buffer data, load the buffer tag, set the buffer valid, go to DONE.
- DONE: `stall`=0 for exactly one cycle, `mem_req`=0, next state IDLE.
- `imem_data_in` and `dmem_data_in` hold their values until next overwritten.
- Buffer hit means valid and tag == `imem_addr`. On a hit `imem_data_in` is loaded from the buffer in IDLE.

Handshake rules:
- Address, `we` and `wdata` are stable while `mem_req`=1 and no ack has been seen.
- `mem_ack` is sampled only when `mem_req`=1; `mem_ack` with `mem_req`=0 is ignored.
- Zero-wait memory (ack in the first req cycle) is legal.

Latency with zero-wait memory (cycles per CPU advance):
- 2 with buffer hit and no data access.
- 3 with a fetch only.
- 4 with a data access plus a fetch.
- Each memory wait state adds 1.

Watchdog:
- Counts cycles with `mem_req`=1 and `mem_ack`=0; clears on ack or state change.
- On reaching TIMEOUT:
  - Complete the access as if acked with `mem_rdata` = 32'h0.
  - Set `bus_error`; it stays set until reset.
  - Do not update the fetch buffer (buffer remains invalid after a fetch timeout).
- Ack arriving on the same edge as the timeout: the ack wins and no error is flagged.

Decomposition:
- Shared package openfire_arb_pkg holds:
  - state encodings (IDLE=2'd0, DACC=2'd1, IFETCH=2'd2, DONE=2'd3);
  - TIMEOUT default;
  - the timeout read-data constant 32'h0.
- One sub-module: openfire_arb_watchdog (counter, clear, enable, `expired` output), parameterised by TIMEOUT/TIMEOUT_W.
- The buffer and the FSM stay in the top module.

Test Plan:
- Fetch only, zero-wait memory, `imem_addr`=0x10, `mem_rdata`=0xB8000004 → `mem_req` high 1 cycle; `stall` low on cycle 3; `imem_data_in`=0xB8000004.
- Repeat the same `imem_addr`=0x10 with no data access → no `mem_req`; `stall` low on cycle 2; `imem_data_in` unchanged.
- Load at `dmem_addr`=0x40, ack after 3 wait states, `mem_rdata`=0x12345678, then fetch 0x14 → `mem_req` continuous; `mem_addr` goes 0x40 then 0x14; `dmem_data_in`=0x12345678; `stall` low on cycle 7.
- Store 0xCAFEF00D to 0x10 while the buffer holds tag 0x10, then fetch 0x10 → `mem_we`=1 with correct wdata; the buffer is invalidated and a new bus fetch of 0x10 occurs.
- `mem_ack` never asserted, TIMEOUT=4 → `mem_req` drops after 4 cycles; `bus_error`=1; `imem_data_in`=0; the next fetch of the same address goes to the bus.
- Reset asserted mid-IFETCH with a wait state pending → `mem_req`=0, `stall`=1 and `bus_error`=0 immediately, no data captured; after release, normal fetch proceeds.

Source files
------------

// File: rtl/openfire_arb_pkg.sv
// Shared definitions for the OpenFire instruction/data memory arbiter.
package openfire_arb_pkg;

  // Arbiter sequencing: sample, data access, instruction fetch, release CPU.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DACC   = 2'd1,
    IFETCH = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Default number of unacknowledged request cycles before an access is aborted.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Read data handed to the CPU when an access is aborted by the watchdog.
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/openfire_arb_watchdog.sv
// Bus watchdog: counts unacknowledged request cycles and flags expiry on the
// cycle the count reaches TIMEOUT, so the access can be completed on that edge.
module openfire_arb_watchdog
  import openfire_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count;

  // Wait-cycle counter; restarts whenever the access ends or the arbiter moves on.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // enable already excludes an ack cycle, so an ack on the expiry edge wins.
  assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/openfire_mem_arbiter.sv
// Shares one single-port memory between the CPU fetch and data ports. Each CPU
// cycle runs the data access (older instruction) before the fetch, with a
// one-entry fetch buffer that skips the bus for a repeated fetch address.
module openfire_mem_arbiter
  import openfire_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] imem_addr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_data_out,
  input  logic        dmem_we,
  input  logic        dmem_re,
  output logic [31:0] imem_data_in,
  output logic [31:0] dmem_data_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);

  arb_state_t  state, state_next;

  logic [31:0] imem_addr_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wdata_q;
  logic        is_store_q;
  logic        is_load_q;

  logic        buf_valid;
  logic [31:0] buf_tag;
  logic [31:0] buf_data;

  logic        in_access;
  logic        wd_enable;
  logic        wd_clear;
  logic        expired;
  logic        idle_hit;
  logic        store_hits_buf;
  logic        fetch_miss;

  assign in_access      = (state == DACC) || (state == IFETCH);
  assign mem_req        = in_access;
  assign wd_enable      = in_access && !mem_ack;
  assign wd_clear       = mem_ack || (state_next != state);

  assign idle_hit       = buf_valid && (buf_tag == imem_addr);
  assign store_hits_buf = is_store_q && buf_valid && (dmem_addr_q == buf_tag);
  // A store to the buffered address forces the following fetch onto the bus.
  assign fetch_miss     = !buf_valid || store_hits_buf || (buf_tag != imem_addr_q);

  openfire_arb_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (expired)
  );

  // State register; asynchronous reset drops mem_req at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and bus/CPU control outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = state;
    stall      = 1'b1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        if (dmem_we || dmem_re) begin
          state_next = DACC;
        end else if (!idle_hit) begin
          state_next = IFETCH;
        end else begin
          state_next = DONE;
        end
      end
      DACC: begin
        mem_addr  = dmem_addr_q;
        mem_we    = is_store_q;
        mem_wdata = dmem_wdata_q;
        if (mem_ack || expired) begin
          state_next = fetch_miss ? IFETCH : DONE;
        end
      end
      IFETCH: begin
        mem_addr = imem_addr_q;
        if (mem_ack || expired) begin
          state_next = DONE;
        end
      end
      DONE: begin
        stall      = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, read-data return, fetch buffer and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      imem_addr_q  <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      is_store_q   <= 1'b0;
      is_load_q    <= 1'b0;
      buf_valid    <= 1'b0;
      buf_tag      <= '0;
      buf_data     <= '0;
      imem_data_in <= '0;
      dmem_data_in <= '0;
      bus_error    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          imem_addr_q  <= imem_addr;
          dmem_addr_q  <= dmem_addr;
          dmem_wdata_q <= dmem_data_out;
          is_store_q   <= dmem_we;
          is_load_q    <= dmem_re && !dmem_we;
          if (idle_hit) begin
            imem_data_in <= buf_data;
          end
        end
        DACC: begin
          if (mem_ack || expired) begin
            if (is_load_q) begin
              dmem_data_in <= mem_ack ? mem_rdata : TIMEOUT_RDATA;
            end
            if (store_hits_buf) begin
              buf_valid <= 1'b0;
            end
            if (!mem_ack) begin
              bus_error <= 1'b1;
            end
          end
        end
        IFETCH: begin
          if (mem_ack) begin
            imem_data_in <= mem_rdata;
            buf_data     <= mem_rdata;
            buf_tag      <= imem_addr_q;
            buf_valid    <= 1'b1;
          end else if (expired) begin
            imem_data_in <= TIMEOUT_RDATA;
            bus_error    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_openfire_mem_arbiter.sv
// Bench for openfire_mem_arbiter: directed scenarios followed by randomized CPU
// cycles, checked against a transaction-level model of the arbiter.
module tb_openfire_mem_arbiter;

  localparam int TO = 4;

  logic        clock;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_out;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] imem_data_in;
  logic [31:0] dmem_data_in;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_error;

  int vectors;
  int miscompares;

  // Environment memory and reference-model state.
  logic [31:0] mem [logic [31:0]];
  logic        m_bv;
  logic [31:0] m_bt;
  logic [31:0] m_bd;
  logic [31:0] m_imem;
  logic [31:0] m_dmem;
  logic        m_berr;

  openfire_mem_arbiter #(
    .TIMEOUT   (TO),
    .TIMEOUT_W (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .dmem_addr     (dmem_addr),
    .dmem_data_out (dmem_data_out),
    .dmem_we       (dmem_we),
    .dmem_re       (dmem_re),
    .imem_data_in  (imem_data_in),
    .dmem_data_in  (dmem_data_in),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .bus_error     (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 0) return TO;
    if (r == 1) return TO + 3;
    if (r < 4)  return TO - 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic model_reset();
    m_bv   = 1'b0;
    m_bt   = '0;
    m_bd   = '0;
    m_imem = '0;
    m_dmem = '0;
    m_berr = 1'b0;
  endtask

  // One CPU cycle. Called during an IDLE cycle before its sampling edge; returns
  // one cycle after DONE, again inside IDLE. w0/w1 are the wait states given to
  // the first/second bus access (any count >= TO means the memory never acks).
  task automatic run_op(input logic we, input logic re, input logic [31:0] daddr,
                        input logic [31:0] wdata, input logic [31:0] iaddr,
                        input int w0, input int w1);
    bit          has_d, d_ok, f_ok, fetch, done, active;
    int          wd, wf, exp_cyc, cyc, idx, cnt, wt, n;
    logic [31:0] fdata, cur_addr, cur_wd;
    logic        cur_we;
    logic [31:0] ea_addr[$];
    logic        ea_we[$];
    logic [31:0] ea_wd[$];
    logic [31:0] ga_addr[$];
    logic        ga_we[$];
    logic [31:0] ga_wd[$];

    // Expected outcome from the arbiter's rules, against pre-op memory.
    has_d   = we || re;
    wd      = w0;
    wf      = has_d ? w1 : w0;
    d_ok    = (wd + 1 <= TO);
    f_ok    = (wf + 1 <= TO);
    exp_cyc = 2;
    if (m_bv && m_bt == iaddr) m_imem = m_bd;
    if (has_d) begin
      ea_addr.push_back(daddr);
      ea_we.push_back(we);
      ea_wd.push_back(wdata);
      exp_cyc += d_ok ? wd + 1 : TO;
      if (!we) m_dmem = d_ok ? mem_rd(daddr) : 32'h0;
      if (we && m_bv && m_bt == daddr) m_bv = 1'b0;
      if (!d_ok) m_berr = 1'b1;
    end
    fetch = !(m_bv && m_bt == iaddr);
    if (fetch) begin
      fdata = (has_d && we && d_ok && daddr == iaddr) ? wdata : mem_rd(iaddr);
      ea_addr.push_back(iaddr);
      ea_we.push_back(1'b0);
      ea_wd.push_back(32'h0);
      exp_cyc += f_ok ? wf + 1 : TO;
      if (f_ok) begin
        m_imem = fdata;
        m_bv   = 1'b1;
        m_bt   = iaddr;
        m_bd   = fdata;
      end else begin
        m_imem = 32'h0;
        m_berr = 1'b1;
      end
    end

    // Drive the CPU side and act as the memory until the CPU is released.
    imem_addr     = iaddr;
    dmem_addr     = daddr;
    dmem_data_out = wdata;
    dmem_we       = we;
    dmem_re       = re;
    done   = 1'b0;
    active = 1'b0;
    cyc    = 0;
    idx    = 0;
    cnt    = 0;
    wt     = 0;
    while (!done && cyc < 200) begin
      cyc++;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (!active) begin
          active   = 1'b1;
          cnt      = 0;
          wt       = (idx == 0) ? w0 : w1;
          idx++;
          cur_addr = mem_addr;
          cur_we   = mem_we;
          cur_wd   = mem_wdata;
          ga_addr.push_back(mem_addr);
          ga_we.push_back(mem_we);
          ga_wd.push_back(mem_wdata);
        end else begin
          check("hold_addr", mem_addr, cur_addr);
          check("hold_we", mem_we, cur_we);
          if (cur_we) check("hold_wdata", mem_wdata, cur_wd);
        end
        if (cnt == wt) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata     = mem_rd(mem_addr);
          active = 1'b0;
        end else if (cnt == TO - 1) begin
          active = 1'b0;
        end
        cnt++;
      end else begin
        active  = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
      end
      if (!stall) begin
        done = 1'b1;
      end else begin
        @(posedge clock);
        #1;
      end
    end

    check("op_done", done, 1'b1);
    check("cycles", cyc, exp_cyc);
    check("n_acc", ga_addr.size(), ea_addr.size());
    n = (ga_addr.size() < ea_addr.size()) ? ga_addr.size() : ea_addr.size();
    for (int i = 0; i < n; i++) begin
      check("acc_addr", ga_addr[i], ea_addr[i]);
      check("acc_we", ga_we[i], ea_we[i]);
      if (ea_we[i]) check("acc_wdata", ga_wd[i], ea_wd[i]);
    end
    check("imem_data_in", imem_data_in, m_imem);
    check("dmem_data_in", dmem_data_in, m_dmem);
    check("bus_error", bus_error, m_berr);

    // DONE lasts exactly one cycle.
    mem_ack = 1'b0;
    @(posedge clock);
    #1;
    check("stall_after_done", stall, 1'b1);
    check("req_after_done", mem_req, 1'b0);
  endtask

  initial begin
    logic        r_we, r_re;
    logic [31:0] r_ia, r_da;
    int          r;

    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    imem_addr     = '0;
    dmem_addr     = '0;
    dmem_data_out = '0;
    dmem_we       = 1'b0;
    dmem_re       = 1'b0;
    mem_rdata     = '0;
    mem_ack       = 1'b0;
    mem[32'h10]   = 32'hB8000004;
    mem[32'h40]   = 32'h12345678;
    model_reset();

    repeat (3) @(posedge clock);
    #1;
    check("rst_stall", stall, 1'b1);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_imem", imem_data_in, 32'h0);
    check("rst_dmem", dmem_data_in, 32'h0);
    check("rst_berr", bus_error, 1'b0);
    reset = 1'b0;

    // Fetch only, zero wait: three cycles.
    run_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h10, 0, 0);
    check("t1_imem", imem_data_in, 32'hB8000004);
    // Same address again: buffer hit, two cycles, no bus traffic.
    run_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h10, 0, 0);
    check("t2_imem", imem_data_in, 32'hB8000004);
    // Load with three wait states, then fetch 0x14 back-to-back: seven cycles.
    run_op(1'b0, 1'b1, 32'h40, 32'h0, 32'h14, 3, 0);
    check("t3_dmem", dmem_data_in, 32'h12345678);
    // Refill buffer with 0x10, then store to 0x10 and fetch 0x10.
    run_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h10, 1, 0);
    run_op(1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 32'h10, 0, 0);
    check("t4_imem", imem_data_in, 32'hCAFEF00D);
    // Fetch that is never acknowledged, then the same fetch again.
    run_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h30, 100, 0);
    check("t5_berr", bus_error, 1'b1);
    check("t5_imem", imem_data_in, 32'h0);
    run_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h30, 0, 0);

    // Reset in the middle of a waited fetch.
    imem_addr = 32'h50;
    dmem_we   = 1'b0;
    dmem_re   = 1'b0;
    mem_ack   = 1'b0;
    @(posedge clock);
    #1;
    check("t6_req_before", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_req", mem_req, 1'b0);
    check("t6_stall", stall, 1'b1);
    check("t6_berr", bus_error, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    @(posedge clock);
    #1;
    check("t6_imem", imem_data_in, 32'h0);
    mem_ack = 1'b0;
    reset   = 1'b0;
    model_reset();
    run_op(1'b0, 1'b0, 32'h0, 32'h0, 32'h50, 1, 0);

    // Randomized CPU cycles over a small address set to exercise hits and aliasing.
    for (int k = 0; k < 300; k++) begin
      r    = int'($urandom_range(0, 3));
      r_we = (r >= 2);
      r_re = (r == 1) || (r == 3);
      r_ia = 32'h10 + 32'(4 * $urandom_range(0, 3));
      r_da = $urandom_range(0, 1) ? (32'h10 + 32'(4 * $urandom_range(0, 3)))
                                  : (32'h40 + 32'(4 * $urandom_range(0, 3)));
      run_op(r_we, r_re, r_da, $urandom, r_ia, pick_wait(), pick_wait());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
